// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared board size, coordinate type, state enum and cursor step helper
package battleship_pkg;

  localparam int BOARD_N = 5;
  localparam int COORD_W = 5;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    PLACE,
    AIM,
    CHECK,
    REPORT,
    DONE
  } state_t;

  // One-cell step with wrap; opposing requests cancel and leave the value unchanged.
  function automatic coord_t wrap_step(coord_t v, logic inc, logic dec, int n);
    coord_t r;
    r = v;
    if (inc && !dec) begin
      r = (v == coord_t'(n - 1)) ? '0 : v + 1'b1;
    end else if (dec && !inc) begin
      r = (v == '0) ? coord_t'(n - 1) : v - 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/shot_resolver_if.sv
// rtl/shot_resolver_if.sv - button, placement and shot-result signals of the shot resolver
interface shot_resolver_if;
  import battleship_pkg::*;

  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       btn_fire;
  logic       place_en;
  logic       start;
  coord_t     row_sel;
  coord_t     col_sel;
  logic       shot_valid;
  logic       hit;
  logic       repeat_shot;
  logic [4:0] cells_left;
  logic       all_sunk;
  logic       busy;

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_fire, place_en, start,
    output row_sel, col_sel, shot_valid, hit, repeat_shot, cells_left, all_sunk, busy
  );

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_fire, place_en, start,
    input  row_sel, col_sel, shot_valid, hit, repeat_shot, cells_left, all_sunk, busy
  );

endinterface

// File: rtl/cursor_ctrl.sv
// rtl/cursor_ctrl.sv - wrapping row/column cursor driven by move pulses
module cursor_ctrl #(
  parameter int BOARD_N = battleship_pkg::BOARD_N
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  move_en,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  output battleship_pkg::coord_t row,
  output battleship_pkg::coord_t col
);
  import battleship_pkg::*;

  coord_t row_q, row_d;
  coord_t col_q, col_d;

  // Up/left decrement, down/right increment, both wrapping at the board edge.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (move_en) begin
      row_d = wrap_step(row_q, btn_down, btn_up, BOARD_N);
      col_d = wrap_step(col_q, btn_right, btn_left, BOARD_N);
    end
  end

  // Cursor registers, home is (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/shot_resolver.sv
// rtl/shot_resolver.sv - ship placement, shot checking and sunk tracking for one board
module shot_resolver #(
  parameter int BOARD_N        = battleship_pkg::BOARD_N,
  parameter int MAX_SHIP_CELLS = 9
) (
  input logic            clk,
  input logic            rst,
  shot_resolver_if.slave bus
);
  import battleship_pkg::*;

  localparam int IW = (BOARD_N > 1) ? $clog2(BOARD_N) : 1;

  state_t                          state_q, state_d;
  coord_t                          row, col;
  logic [IW-1:0]                   cur_r, cur_c;
  logic [IW-1:0]                   tgt_r_q, tgt_r_d, tgt_c_q, tgt_c_d;
  logic [BOARD_N-1:0][BOARD_N-1:0] ship_q, ship_d;
  logic [BOARD_N-1:0][BOARD_N-1:0] shot_q, shot_d;
  logic                            ship_bit_q, ship_bit_d;
  logic                            shot_bit_q, shot_bit_d;
  logic [4:0]                      cells_left_q, cells_left_d;
  logic                            move_en;
  logic                            report;
  logic                            hit_w;

  // The cursor freezes while a shot is in flight and on the fire cycle itself.
  assign move_en = (state_q != CHECK) && (state_q != REPORT) &&
                   !((state_q == AIM) && bus.btn_fire);

  cursor_ctrl #(.BOARD_N(BOARD_N)) u_cursor (
    .clk       (clk),
    .rst       (rst),
    .move_en   (move_en),
    .btn_up    (bus.btn_up),
    .btn_down  (bus.btn_down),
    .btn_left  (bus.btn_left),
    .btn_right (bus.btn_right),
    .row       (row),
    .col       (col)
  );

  assign cur_r  = row[IW-1:0];
  assign cur_c  = col[IW-1:0];
  assign report = (state_q == REPORT);
  assign hit_w  = report && ship_bit_q && !shot_bit_q;

  // Next-state, board updates and cell-count bookkeeping.
  always_comb begin
    state_d      = state_q;
    tgt_r_d      = tgt_r_q;
    tgt_c_d      = tgt_c_q;
    ship_d       = ship_q;
    shot_d       = shot_q;
    ship_bit_d   = ship_bit_q;
    shot_bit_d   = shot_bit_q;
    cells_left_d = cells_left_q;
    case (state_q)
      PLACE: begin
        if (bus.place_en && !ship_q[cur_r][cur_c] &&
            (cells_left_q < 5'(MAX_SHIP_CELLS))) begin
          ship_d[cur_r][cur_c] = 1'b1;
          cells_left_d         = cells_left_q + 5'd1;
        end
        if (bus.start && (cells_left_q != '0)) begin
          state_d = AIM;
        end
      end
      AIM: begin
        if (bus.btn_fire) begin
          tgt_r_d = cur_r;
          tgt_c_d = cur_c;
          state_d = CHECK;
        end
      end
      CHECK: begin
        ship_bit_d = ship_q[tgt_r_q][tgt_c_q];
        shot_bit_d = shot_q[tgt_r_q][tgt_c_q];
        state_d    = REPORT;
      end
      REPORT: begin
        shot_d[tgt_r_q][tgt_c_q] = 1'b1;
        if (hit_w) begin
          cells_left_d = cells_left_q - 5'd1;
        end
        state_d = (cells_left_d == '0) ? DONE : AIM;
      end
      DONE: begin
      end
      default: state_d = PLACE;
    endcase
  end

  // State, board and shot-pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PLACE;
      tgt_r_q      <= '0;
      tgt_c_q      <= '0;
      ship_q       <= '0;
      shot_q       <= '0;
      ship_bit_q   <= 1'b0;
      shot_bit_q   <= 1'b0;
      cells_left_q <= '0;
    end else begin
      state_q      <= state_d;
      tgt_r_q      <= tgt_r_d;
      tgt_c_q      <= tgt_c_d;
      ship_q       <= ship_d;
      shot_q       <= shot_d;
      ship_bit_q   <= ship_bit_d;
      shot_bit_q   <= shot_bit_d;
      cells_left_q <= cells_left_d;
    end
  end

  assign bus.row_sel     = row;
  assign bus.col_sel     = col;
  assign bus.shot_valid  = report;
  assign bus.hit         = hit_w;
  assign bus.repeat_shot = report && shot_bit_q;
  assign bus.cells_left  = cells_left_q;
  assign bus.all_sunk    = (state_q == DONE);
  assign bus.busy        = (state_q == CHECK) || report;

endmodule

// File: tb/tb_shot_resolver.sv
// tb/tb_shot_resolver.sv - scoreboard bench for shot_resolver
module tb_shot_resolver;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shot_resolver_if dut_if ();

  shot_resolver #(.BOARD_N(5), .MAX_SHIP_CELLS(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  typedef struct {
    int   cyc;
    logic hit;
    logic rep;
    int   cl;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic cl_pending = 1'b0;
  int   exp_cl = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Result monitor: every shot_valid must match the oldest expected shot.
  always @(negedge clk) begin
    if (!rst) begin
      if (cl_pending) begin
        check("cells_left_after_shot", 32'(dut_if.cells_left), 32'(exp_cl));
        cl_pending = 1'b0;
      end
      if (dut_if.shot_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_shot_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("shot_valid_cycle", 32'(cyc), 32'(e.cyc));
          check("hit", 32'(dut_if.hit), 32'(e.hit));
          check("repeat_shot", 32'(dut_if.repeat_shot), 32'(e.rep));
          exp_cl     = e.cl;
          cl_pending = 1'b1;
        end
      end else if (dut_if.hit || dut_if.repeat_shot) begin
        check("flags_without_valid", 32'({dut_if.hit, dut_if.repeat_shot}), 32'd0);
      end
    end
  end

  task automatic clear_inputs();
    dut_if.btn_up    = 1'b0;
    dut_if.btn_down  = 1'b0;
    dut_if.btn_left  = 1'b0;
    dut_if.btn_right = 1'b0;
    dut_if.btn_fire  = 1'b0;
    dut_if.place_en  = 1'b0;
    dut_if.start     = 1'b0;
  endtask

  // One-cycle pulse on the selected inputs; returns just after the sampling edge.
  task automatic press(logic up, logic down, logic left, logic right,
                       logic fire, logic place, logic st);
    @(posedge clk);
    #1;
    dut_if.btn_up    = up;
    dut_if.btn_down  = down;
    dut_if.btn_left  = left;
    dut_if.btn_right = right;
    dut_if.btn_fire  = fire;
    dut_if.place_en  = place;
    dut_if.start     = st;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic fire(logic e_hit, logic e_rep, int e_cl, logic with_move);
    exp_t e;
    @(posedge clk);
    #1;
    dut_if.btn_fire  = 1'b1;
    dut_if.btn_right = with_move;
    e.cyc = cyc + 2;
    e.hit = e_hit;
    e.rep = e_rep;
    e.cl  = e_cl;
    sb.push_back(e);
    @(posedge clk);
    #1;
    clear_inputs();
    check("busy_after_fire", 32'(dut_if.busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (sb.size() == 0 && !cl_pending) break;
      @(posedge clk);
      #1;
    end
    if (sb.size() != 0 || cl_pending) begin
      check("shot_timeout", 32'd0, 32'd1);
      sb.delete();
      cl_pending = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_row"}, 32'(dut_if.row_sel), 32'd0);
    check({tag, "_col"}, 32'(dut_if.col_sel), 32'd0);
    check({tag, "_shot_valid"}, 32'(dut_if.shot_valid), 32'd0);
    check({tag, "_hit"}, 32'(dut_if.hit), 32'd0);
    check({tag, "_repeat"}, 32'(dut_if.repeat_shot), 32'd0);
    check({tag, "_cells_left"}, 32'(dut_if.cells_left), 32'd0);
    check({tag, "_all_sunk"}, 32'(dut_if.all_sunk), 32'd0);
    check({tag, "_busy"}, 32'(dut_if.busy), 32'd0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Start with nothing placed and fire during placement are both ignored.
    press(0, 0, 0, 0, 0, 0, 1);
    press(0, 0, 0, 0, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("busy_in_place", 32'(dut_if.busy), 32'd0);

    // Placement at (0,0) and (1,1), duplicate at (1,1) ignored.
    press(0, 0, 0, 0, 0, 1, 0);
    check("place_first", 32'(dut_if.cells_left), 32'd1);
    press(0, 1, 0, 1, 0, 0, 0);
    check("cursor_row_1", 32'(dut_if.row_sel), 32'd1);
    check("cursor_col_1", 32'(dut_if.col_sel), 32'd1);
    press(0, 0, 0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 0, 1, 0);
    check("place_duplicate", 32'(dut_if.cells_left), 32'd2);

    // Row wrap downward from 0 and cancelling left+right.
    press(1, 0, 0, 0, 0, 0, 0);
    check("row_up_to_0", 32'(dut_if.row_sel), 32'd0);
    press(1, 0, 0, 0, 0, 0, 0);
    check("row_wrap_to_4", 32'(dut_if.row_sel), 32'd4);
    press(0, 0, 1, 1, 0, 0, 0);
    check("col_left_right_hold", 32'(dut_if.col_sel), 32'd1);
    press(0, 1, 1, 0, 0, 0, 0);
    check("row_wrap_to_0", 32'(dut_if.row_sel), 32'd0);
    check("col_back_0", 32'(dut_if.col_sel), 32'd0);

    // Aim and shoot.
    press(0, 0, 0, 0, 0, 0, 1);
    check("busy_in_aim", 32'(dut_if.busy), 32'd0);
    fire(1'b1, 1'b0, 1, 1'b0);
    fire(1'b0, 1'b1, 1, 1'b1);
    check("col_frozen_on_fire", 32'(dut_if.col_sel), 32'd0);
    press(0, 1, 0, 1, 0, 0, 0);
    fire(1'b1, 1'b0, 0, 1'b0);
    check("all_sunk_done", 32'(dut_if.all_sunk), 32'd1);
    check("busy_done", 32'(dut_if.busy), 32'd0);

    // DONE ignores fire, start and place_en.
    press(0, 0, 0, 0, 1, 0, 0);
    press(0, 0, 0, 0, 0, 1, 1);
    repeat (4) @(posedge clk);
    #1;
    check("done_cells_left", 32'(dut_if.cells_left), 32'd0);
    check("done_stays", 32'(dut_if.all_sunk), 32'd1);

    // Reset in the cycle after a fire aborts the shot.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    press(0, 0, 0, 0, 0, 1, 0);
    press(0, 0, 0, 0, 0, 0, 1);
    press(0, 0, 0, 0, 1, 0, 0);
    check("busy_before_abort", 32'(dut_if.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_reset_outputs("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shot_resolver.md
SHOT_RESOLVER -- requirements
Module: shot_resolver

Interface
REQ-001 The block SHALL have parameter BOARD_N, default 5, meaning board side length in cells.
REQ-002 The block SHALL have parameter MAX_SHIP_CELLS, default 9, meaning the maximum number of ship cells that may be placed.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port btn_up / btn_down / btn_left / btn_right, input, 1 bit each: single-cycle cursor-move pulses.
REQ-006 The block SHALL have port btn_fire, input, 1 bit: single-cycle fire request.
REQ-007 The block SHALL have port place_en, input, 1 bit: marks a ship cell at the cursor during placement.
REQ-008 The block SHALL have port start, input, 1 bit: ends placement.
REQ-009 The block SHALL have port row_sel, output, 5 bits: binary cursor row.
REQ-010 The block SHALL have port col_sel, output, 5 bits: binary cursor column.
REQ-011 The block SHALL have port shot_valid, output, 1 bit: a one-cycle pulse that qualifies the shot result.
REQ-012 The block SHALL have port hit, output, 1 bit: the shot landed on an unsunk ship cell.
REQ-013 The block SHALL have port repeat_shot, output, 1 bit: the cell had already been fired on.
REQ-014 The block SHALL have port cells_left, output, 5 bits: the count of ship cells not yet hit.
REQ-015 The block SHALL have port all_sunk, output, 1 bit: level output, high in DONE.
REQ-016 The block SHALL have port busy, output, 1 bit: high in CHECK and REPORT.

Function
REQ-017 The block SHALL implement states PLACE, AIM, CHECK, REPORT and DONE.
REQ-018 The cursor SHALL move one cell per move pulse, in every state except CHECK and REPORT, and SHALL wrap from 0 to BOARD_N-1 and from BOARD_N-1 to 0.
REQ-019 When btn_up and btn_down are high in the same cycle, the row SHALL not change; when btn_left and btn_right are high in the same cycle, the column SHALL not change.
REQ-020 In PLACE, place_en SHALL set the ship bit at the cursor and increment cells_left only if the bit was clear and cells_left < MAX_SHIP_CELLS; otherwise place_en SHALL have no effect.
REQ-021 PLACE SHALL move to AIM on start when cells_left > 0; start with cells_left == 0 SHALL be ignored.
REQ-022 In AIM, btn_fire SHALL latch the current cursor coordinate and move to CHECK; any move pulse in the same cycle SHALL be ignored.
REQ-023 CHECK SHALL read the ship bit and shot bit of the latched cell, then move to REPORT.
REQ-024 In REPORT, shot_valid SHALL be high for exactly one cycle, two cycles after the fire cycle.
REQ-025 In REPORT, hit SHALL be 1 only when the ship bit is 1 and the shot bit is 0, and repeat_shot SHALL equal the old shot bit.
REQ-026 In REPORT, the shot bit SHALL be set, and cells_left SHALL decrement by 1 on a hit, with the new value visible in the cycle after shot_valid.
REQ-027 REPORT SHALL go to DONE if cells_left reaches 0, else to AIM.
REQ-028 btn_fire SHALL be ignored in PLACE, CHECK, REPORT and DONE.
REQ-029 btn_fire, place_en and start SHALL be ignored in DONE, which is left only by rst.
REQ-030 hit and repeat_shot SHALL be 0 whenever shot_valid is 0.
REQ-031 row_sel and col_sel SHALL always be < BOARD_N.

Reset
REQ-032 rst SHALL asynchronously force state PLACE, cursor (0,0), all ship and shot bits 0, cells_left 0, and shot_valid, hit, repeat_shot, all_sunk and busy all 0.
REQ-033 rst asserted in CHECK or REPORT SHALL abort the shot with no result pulse.

Structure
REQ-034 BOARD_N, the state enum and a coordinate typedef SHALL reside in shared package battleship_pkg.
REQ-035 Cursor wrap and move logic SHALL be the sub-module cursor_ctrl.
REQ-036 Board storage SHALL be two BOARD_N x BOARD_N bit arrays, one for ships and one for shots.

Verification
REQ-037 The bench SHALL cover: place at (0,0),(1,1), then press place_en at (1,1) again -> cells_left = 2.
REQ-038 The bench SHALL cover: btn_up at row 0 -> row_sel = 4; btn_left+btn_right together -> column unchanged.
REQ-039 The bench SHALL cover: start, then fire at (0,0) -> shot_valid at fire+2 with hit = 1, then cells_left = 1.
REQ-040 The bench SHALL cover: fire at (0,0) again -> hit = 0, repeat_shot = 1, cells_left = 1.
REQ-041 The bench SHALL cover: fire at (1,1) -> hit = 1, cells_left = 0, all_sunk = 1; a further btn_fire -> no shot_valid.
REQ-042 The bench SHALL cover: rst asserted the cycle after a fire -> no shot_valid, and all outputs at their reset values.
